// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake,
// with a fixed number of wait states between accepting a request and answering it.
module dmem_responder #(
   parameter int ADDR_W      = 7,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        wr_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic        rsp_err_q;
   logic [15:0] rsp_rdata_q;
   logic [15:0] mem_q [DEPTH];

   logic              accept;
   logic              enter_resp;
   logic              cur_write;
   logic [15:0]       cur_addr;
   logic [15:0]       cur_wdata;
   logic              in_range;
   logic [ADDR_W-1:0] idx;
   logic              rsp_err_d;
   logic [15:0]       rsp_rdata_d;

   // With zero wait states RESP is entered on the accept edge itself, so the
   // live request inputs stand in for the not-yet-latched copies.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cur_write  = wr_q;
      cur_addr   = addr_q;
      cur_wdata  = wdata_q;
      accept     = (state_q == IDLE) && req_ready_q && req_valid;
      enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
      if (state_q == IDLE) begin
         cur_write = req_write;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
         if (WAIT_CYCLES == 0)
            enter_resp = accept;
      end
      in_range    = (cur_addr >> ADDR_W) == 16'd0;
      idx         = cur_addr[ADDR_W-1:0];
      rsp_err_d   = !in_range;
      rsp_rdata_d = (in_range && !cur_write) ? mem_q[idx] : 16'd0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         addr_q      <= 16'd0;
         wdata_q     <= 16'd0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 16'd0;
      end else begin
         if (enter_resp) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  wr_q        <= req_write;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  req_ready_q <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= 4'(WAIT_CYCLES - 1);
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) state_q <= RESP;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            RESP: begin
               // Ready stays low for the cycle after consumption; IDLE raises it.
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= 16'd0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: storage is deliberately left out of reset; only an abandoned
   // transaction is blocked from committing while reset is asserted.
   always_ff @(posedge clk) begin
      if (resetn && enter_resp && cur_write && in_range)
         mem_q[idx] <= cur_wdata;
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a WAIT_CYCLES=2 instance checked against
// an array model, plus a WAIT_CYCLES=0 instance for the back-to-back cadence.
module tb_dmem_responder;

   localparam int A_W    = 7;
   localparam int A_WAIT = 2;
   localparam int BUDGET = 40;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid_a, req_valid_b;
   logic        req_write;
   logic [15:0] req_addr, req_wdata;
   logic        rsp_ready;

   logic        a_req_ready, a_rsp_valid, a_rsp_err;
   logic [15:0] a_rsp_rdata;
   logic        b_req_ready, b_rsp_valid, b_rsp_err;
   logic [15:0] b_rsp_rdata;

   logic [15:0] model_mem [1 << A_W];
   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(A_W), .WAIT_CYCLES(A_WAIT)) dut_a (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid_a), .req_ready(a_req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   dmem_responder #(.ADDR_W(7), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid_b), .req_ready(b_req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_inputs(input bit en);
      if (en) begin
         req_addr  = 16'($urandom);
         req_wdata = 16'($urandom);
         req_write = 1'($urandom);
      end
   endtask

   // One full transaction on instance A, checked against the array model.
   task automatic txn_a(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                        input int hold, input bit scramble);
      int          k;
      bit          in_rng;
      logic [15:0] exp_rdata;
      in_rng    = (addr >> A_W) == 16'd0;
      exp_rdata = (in_rng && !wr) ? model_mem[addr[A_W-1:0]] : 16'h0000;
      rsp_ready = 1'b0;
      k = 0;
      while (!a_req_ready && k < BUDGET) begin
         tick();
         k++;
      end
      check("req_ready_wait", a_req_ready, 1);
      req_valid_a = 1'b1;
      req_write   = wr;
      req_addr    = addr;
      req_wdata   = data;
      tick();
      req_valid_a = 1'b0;
      scramble_inputs(scramble);
      k = 0;
      while (!a_rsp_valid && k < BUDGET) begin
         tick();
         scramble_inputs(scramble);
         k++;
      end
      check("latency", k + 1, A_WAIT + 1);
      check("rdata", a_rsp_rdata, exp_rdata);
      check("err", a_rsp_err, !in_rng);
      for (int h = 0; h < hold; h++) begin
         tick();
         scramble_inputs(scramble);
         check("hold_valid", a_rsp_valid, 1);
         check("hold_rdata", a_rsp_rdata, exp_rdata);
         check("hold_err", a_rsp_err, !in_rng);
         check("hold_no_ready", a_req_ready, 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_consumed", a_rsp_valid, 0);
      check("no_ready_on_consume", a_req_ready, 0);
      if (in_rng && wr) model_mem[addr[A_W-1:0]] = data;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] addr, last_addr;
      bit          wr;
      int          last, nacc;
      resetn      = 1'b0;
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      req_write   = 1'b0;
      req_addr    = 16'h0;
      req_wdata   = 16'h0;
      rsp_ready   = 1'b1;
      repeat (3) tick();
      check("rst_a_req_ready", a_req_ready, 0);
      check("rst_a_rsp_valid", a_rsp_valid, 0);
      check("rst_a_rsp_err", a_rsp_err, 0);
      check("rst_a_rsp_rdata", a_rsp_rdata, 0);
      check("rst_b_req_ready", b_req_ready, 0);
      check("rst_b_rsp_valid", b_rsp_valid, 0);
      resetn = 1'b1;
      tick();
      check("ready_after_rst", a_req_ready, 1);

      // Give every word a known value through ordinary stores.
      for (int i = 0; i < (1 << A_W); i++)
         txn_a(1'b1, 16'(i), 16'($urandom), 0, 1'b0);

      // Store then load the same word.
      txn_a(1'b1, 16'h0005, 16'hBEEF, 0, 1'b0);
      txn_a(1'b0, 16'h0005, 16'h0000, 0, 1'b0);
      check("beef_model", model_mem[5], 16'hBEEF);

      // Out-of-range store must not alias onto word 0.
      txn_a(1'b1, 16'h0080, 16'hDEAD, 0, 1'b0);
      txn_a(1'b0, 16'h0000, 16'h0000, 0, 1'b0);
      txn_a(1'b0, 16'h0080, 16'h0000, 0, 1'b0);
      txn_a(1'b0, 16'hFF00, 16'h0000, 1, 1'b0);

      // Back-pressured load of a 0x1234 word, then ready returns a cycle later.
      txn_a(1'b1, 16'h0033, 16'h1234, 0, 1'b0);
      txn_a(1'b0, 16'h0033, 16'h0000, 5, 1'b0);
      tick();
      check("ready_back", a_req_ready, 1);

      // Reset in the middle of WAIT abandons the store.
      txn_a(1'b1, 16'h0010, 16'h5555, 0, 1'b0);
      while (!a_req_ready) tick();
      req_valid_a = 1'b1;
      req_write   = 1'b1;
      req_addr    = 16'h0010;
      req_wdata   = 16'hAAAA;
      tick();
      req_valid_a = 1'b0;
      tick();
      resetn = 1'b0;
      tick();
      check("abandon_valid", a_rsp_valid, 0);
      check("abandon_ready", a_req_ready, 0);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abandon_no_rsp", a_rsp_valid, 0);
      end
      txn_a(1'b0, 16'h0010, 16'h0000, 0, 1'b0);

      // Inputs churn after accept; the latched request must win.
      txn_a(1'b1, 16'h0042, 16'hC0DE, 2, 1'b1);
      txn_a(1'b0, 16'h0042, 16'h0000, 2, 1'b1);

      // Random traffic, biased toward reusing the previous address.
      last_addr = 16'h0000;
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom);
         case ($urandom_range(0, 5))
            0:       addr = 16'($urandom_range(16'h0080, 16'hFFFF));
            1, 2:    addr = last_addr;
            default: addr = {9'h000, 7'($urandom)};
         endcase
         txn_a(wr, addr, 16'($urandom), $urandom_range(0, 3), 1'($urandom));
         last_addr = addr;
      end

      // Zero-wait instance: continuous requests with rsp_ready tied high.
      rsp_ready   = 1'b1;
      req_valid_b = 1'b1;
      req_write   = 1'b1;
      req_addr    = 16'h007F;
      req_wdata   = 16'h0001;
      last = -1;
      nacc = 0;
      for (int i = 0; i < 10; i++) begin
         bit acc;
         acc = b_req_ready;
         tick();
         if (acc) begin
            check("b_latency", b_rsp_valid, 1);
            check("b_rdata", b_rsp_rdata, (nacc == 0) ? 32'h0 : 32'h1);
            check("b_err", b_rsp_err, 0);
            if (last >= 0) check("b_accept_gap", i - last, 3);
            last = i;
            nacc++;
            req_write = 1'b0;
            req_wdata = 16'hFFFF;
         end
      end
      req_valid_b = 1'b0;
      tick();
      check("b_accept_count", nacc, 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, giving the word-address width of storage (2^ADDR_W 16-bit words).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted between accept and response (legal range 0-15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 16 bits: word address.
REQ-009 The block SHALL have port req_wdata, input, 16 bits: store data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: response available.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: the initiator consumes the response.
REQ-012 The block SHALL have port rsp_rdata, output, 16 bits: load data; 0 for stores and errors.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: the address is out of range.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid=1 and req_ready=1.
REQ-016 On accept, the block SHALL latch req_write, req_addr and req_wdata; later changes on the request inputs have no effect on the transaction.
REQ-017 On accept, if WAIT_CYCLES>0 the block SHALL move to WAIT and load the wait counter with WAIT_CYCLES-1; if WAIT_CYCLES=0 it SHALL move directly to RESP.
REQ-018 In WAIT, the counter SHALL decrement each cycle; the block SHALL move to RESP on the edge where the counter is 0.
REQ-019 The latency from the accept edge to the rsp_valid=1 edge SHALL be exactly WAIT_CYCLES+1 cycles.
REQ-020 An address SHALL be in range iff req_addr[15:ADDR_W]==0; storage is indexed by req_addr[ADDR_W-1:0].
REQ-021 For an in-range store, storage SHALL be written on the same edge that enters RESP, with rsp_rdata=0 and rsp_err=0.
REQ-022 For an in-range load, rsp_rdata SHALL be registered on the edge that enters RESP and reflect all previously committed stores, with rsp_err=0.
REQ-023 For an out-of-range request, the store SHALL be suppressed, and the response SHALL carry rsp_rdata=0 and rsp_err=1.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1; on that edge the block SHALL return to IDLE with rsp_valid=0.
REQ-025 No new request SHALL be accepted on the edge the response is consumed; req_ready rises on the following cycle.
REQ-026 rsp_ready asserted outside RESP SHALL be ignored.
REQ-027 At most one transaction SHALL be outstanding at any time.
REQ-028 Back-to-back requests to the same address SHALL observe strict program order: a load after a store returns the stored value.

Reset
REQ-029 When resetn=0 at a rising edge, the FSM SHALL go to IDLE, the counter SHALL clear, and req_ready, rsp_valid, rsp_err and rsp_rdata SHALL become 0 (req_ready becomes 1 on the first cycle after reset release).
REQ-030 Reset asserted during WAIT SHALL abandon the transaction: the store is not committed and no response is produced.
REQ-031 Storage contents SHALL NOT be affected by reset; the bench SHALL initialise storage via stores.

Verification
REQ-032 Store addr 0x0005 data 0xBEEF, then load 0x0005 (WAIT_CYCLES=2) -> each rsp_valid is seen 3 cycles after accept; the load returns 0xBEEF with rsp_err=0.
REQ-033 Load 0x0080 with ADDR_W=7 -> rsp_err=1 and rsp_rdata=0; a prior store to 0x0080 leaves word 0x0000 unchanged.
REQ-034 Hold rsp_ready=0 for 5 cycles during a load of 0x1234-valued word -> rsp_valid and rsp_rdata stay stable; req_ready=0 throughout; the block goes to IDLE one edge after rsp_ready=1.
REQ-035 WAIT_CYCLES=0, store then load 0x007F data 0x0001 with rsp_ready tied 1 -> 1-cycle latency, accepts every 3rd cycle, and the load returns 0x0001.
REQ-036 Assert resetn=0 in the middle of WAIT for a store of 0xAAAA to 0x0010 holding 0x5555 -> no response; a subsequent load of 0x0010 returns 0x5555.
REQ-037 Change req_addr and req_wdata every cycle after accept -> the response reflects the latched values only.
